// File: rtl/assertion_seq_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module  : assertion_div_pkg
// Brief   : Shared types and constants for the sequential restoring divider.
// Revision: 1.0  initial release
// ============================================================================
package assertion_div_pkg;

    // Default operand width used when the top level is not overridden.
    localparam int DIV_WIDTH = 4;

    // Divider control states, explicitly encoded.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage : assertion_div_pkg
`default_nettype wire

// File: rtl/assertion_seq_divider_div_step.sv
`default_nettype none
// ============================================================================
// Module  : div_step
// Brief   : One combinational restoring shift-subtract step. The partial
//           remainder is shifted left with the next dividend bit appended,
//           the divisor is subtracted in WIDTH+1 bits, and the borrow decides
//           whether the subtraction is kept (quotient bit 1) or restored.
// Revision: 1.0  initial release
// ============================================================================
module div_step
    import assertion_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted_w;
    logic [WIDTH:0] trial_w;

    // Trial subtraction; the MSB of the WIDTH+1 bit result is the borrow.
    // The incoming remainder is always below the divisor, so the shifted
    // value fits in WIDTH+1 bits and a kept difference fits in WIDTH bits.
    always_comb begin
        shifted_w = {rem_i, bit_i};
        trial_w   = shifted_w - {1'b0, div_i};
        qbit_o    = ~trial_w[WIDTH];
        rem_o     = qbit_o ? trial_w[WIDTH-1:0] : shifted_w[WIDTH-1:0];
    end

endmodule : div_step
`default_nettype wire

// File: rtl/assertion_seq_divider.sv
`default_nettype none
// ============================================================================
// Module  : assertion_seq_divider
// Brief   : Sequential unsigned divider with valid/ready handshakes on both
//           sides. One restoring step per cycle, MSB first; divide by zero
//           short-circuits to Q = all ones, R = A. Carries its own input
//           X-check and result-consistency assertions.
// Revision: 1.0  initial release
// ============================================================================
module assertion_seq_divider
    import assertion_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_by_zero
);

    localparam int               CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Control state and handshake flags
    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;

    // Operand and working registers
    logic [WIDTH-1:0] a_q;      // dividend as accepted, kept for checking
    logic [WIDTH-1:0] dvd_q;    // dividend shifted out MSB first
    logic [WIDTH-1:0] div_q;    // divisor as accepted
    logic [WIDTH-1:0] rem_q;    // partial remainder
    logic [WIDTH-1:0] quo_q;    // quotient bits collected so far

    // Result registers, held outside DONE
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic             dbz_q;

    // Next values produced by the current restoring step
    logic [WIDTH-1:0] rem_d;
    logic             qbit_d;
    logic [WIDTH-1:0] quo_d;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i  (rem_q),
        .bit_i  (dvd_q[WIDTH-1]),
        .div_i  (div_q),
        .rem_o  (rem_d),
        .qbit_o (qbit_d)
    );

    assign quo_d = (quo_q << 1) | WIDTH'(qbit_d);

    // Control FSM, iteration counter, operand/result registers. Entering DONE
    // loads the result; out_valid rises one edge later, which gives a uniform
    // one-cycle result latency after the last step (or after a zero-divisor
    // accept). A handshake returns to IDLE, and in_ready only rises on that
    // same edge, so a pair offered during the handshake waits one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            dvd_q       <= '0;
            div_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            q_q         <= '0;
            r_q         <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= A;
                        dvd_q      <= A;
                        div_q      <= B;
                        rem_q      <= '0;
                        quo_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        if (B == '0) begin
                            q_q     <= '1;
                            r_q     <= A;
                            dbz_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end

                CALC: begin
                    dvd_q <= dvd_q << 1;
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == LAST_ITER) begin
                        cnt_q   <= '0;
                        q_q     <= quo_d;
                        r_q     <= rem_d;
                        dbz_q   <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign Q           = q_q;
    assign R           = r_q;
    assign div_by_zero = dbz_q;

    // Reconstruction of the dividend from the held result, full product width.
    logic [2*WIDTH-1:0] chk_sum_w;
    assign chk_sum_w = ({{WIDTH{1'b0}}, q_q} * {{WIDTH{1'b0}}, div_q})
                     + {{WIDTH{1'b0}}, r_q};

    // Warn when an accepted operand pair carries unknown bits.
    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) begin
            a_input_known : assert (!$isunknown(^(A ^ B)))
                else $warning("Input is xx");
        end
    end

    a_result_consistent : assert property (
        @(posedge clk) disable iff (rst)
        (out_valid && !div_by_zero) |->
            ((chk_sum_w == {{WIDTH{1'b0}}, a_q}) && (r_q < div_q))
    ) else $error("Result inconsistent: Q*B+R != A or R >= B");

    a_no_valid_while_ready : assert property (
        @(posedge clk) disable iff (rst)
        !(out_valid && in_ready)
    ) else $error("out_valid and in_ready both high");

endmodule : assertion_seq_divider
`default_nettype wire

// File: tb/tb_assertion_seq_divider.sv
`default_nettype none
// ============================================================================
// Module  : tb_assertion_seq_divider
// Brief   : Directed self-checking bench for the sequential divider.
// Revision: 1.0  initial release
// ============================================================================
module tb_assertion_seq_divider;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] A;
    logic [3:0] B;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] Q;
    logic [3:0] R;
    logic       div_by_zero;

    int errors = 0;
    int checks = 0;

    // Edge bookkeeping for handshake ordering
    int cyc          = 0;
    int acc_n        = 0;
    int last_acc_cyc = -1;
    int last_hs_cyc  = -1;

    assertion_seq_divider #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (A),
        .B           (B),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .Q           (Q),
        .R           (R),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record the edges on which accepts and result handshakes happen.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && in_valid && in_ready) begin
            acc_n        <= acc_n + 1;
            last_acc_cyc <= cyc;
        end
        if (!rst && out_valid && out_ready)
            last_hs_cyc <= cyc;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    // Offer a pair and return just after the accepting edge.
    task automatic accept(input logic [3:0] a, input logic [3:0] b);
        int n = 0;
        @(negedge clk);
        A = a; B = b; in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%b required 1 (A=%0d B=%0d)", in_ready, a, b);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Count edges until out_valid is seen, bounded.
    task automatic wait_valid(output int edges);
        edges = 0;
        while (out_valid !== 1'b1 && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    // Wait until the block is back in IDLE, bounded.
    task automatic wait_idle();
        int n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++; if (Q !== 4'd0)           begin errors++; $display("FAIL reset_q: got %0d required 0", Q); end
        checks++; if (R !== 4'd0)           begin errors++; $display("FAIL reset_r: got %0d required 0", R); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b required 0", div_by_zero); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int e;
        out_ready = 1'b1;
        accept(4'd13, 4'd4);
        wait_valid(e);
        checks++; if (e !== 5)              begin errors++; $display("FAIL basic_latency: got %0d edges required 5", e); end
        checks++; if (Q !== 4'd3)           begin errors++; $display("FAIL basic_q: got %0d required 3", Q); end
        checks++; if (R !== 4'd1)           begin errors++; $display("FAIL basic_r: got %0d required 1", R); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz: got %b required 0", div_by_zero); end
        wait_idle();
    endtask

    task automatic test_div_zero();
        int e;
        out_ready = 1'b1;
        accept(4'd7, 4'd0);
        wait_valid(e);
        checks++; if (e !== 1)              begin errors++; $display("FAIL dz_latency: got %0d edges required 1", e); end
        checks++; if (Q !== 4'hF)           begin errors++; $display("FAIL dz_q: got %b required 1111", Q); end
        checks++; if (R !== 4'h7)           begin errors++; $display("FAIL dz_r: got %b required 0111", R); end
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b required 1", div_by_zero); end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int e;
        int a0;
        int n;
        out_ready = 1'b1;
        @(negedge clk);
        A = 4'd3; B = 4'd9; in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        A = 4'd15; B = 4'd1;
        a0 = acc_n;
        wait_valid(e);
        checks++; if (Q !== 4'd0) begin errors++; $display("FAIL b2b_first_q: got %0d required 0", Q); end
        checks++; if (R !== 4'd3) begin errors++; $display("FAIL b2b_first_r: got %0d required 3", R); end
        n = 0;
        while (acc_n == a0 && n < 20) begin @(posedge clk); #1; n++; end
        in_valid = 1'b0;
        checks++; if (acc_n !== a0 + 1) begin errors++; $display("FAIL b2b_accept_count: got %0d required %0d", acc_n, a0 + 1); end
        checks++;
        if (!(last_acc_cyc > last_hs_cyc)) begin
            errors++;
            $display("FAIL b2b_order: accept edge %0d required after handshake edge %0d", last_acc_cyc, last_hs_cyc);
        end
        wait_valid(e);
        checks++; if (e !== 5)     begin errors++; $display("FAIL b2b_second_latency: got %0d required 5", e); end
        checks++; if (Q !== 4'd15) begin errors++; $display("FAIL b2b_second_q: got %0d required 15", Q); end
        checks++; if (R !== 4'd0)  begin errors++; $display("FAIL b2b_second_r: got %0d required 0", R); end
        wait_idle();
    endtask

    task automatic test_backpressure();
        int e;
        int a0;
        out_ready = 1'b0;
        accept(4'd12, 4'd5);
        wait_valid(e);
        checks++; if (e !== 5) begin errors++; $display("FAIL bp_latency: got %0d required 5", e); end
        a0 = acc_n;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            A = 4'(i); B = 4'd1;
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: cycle %0d got %b required 1", i, out_valid); end
            checks++; if (Q !== 4'd2)         begin errors++; $display("FAIL bp_q: cycle %0d got %0d required 2", i, Q); end
            checks++; if (R !== 4'd2)         begin errors++; $display("FAIL bp_r: cycle %0d got %0d required 2", i, R); end
        end
        in_valid = 1'b0;
        checks++; if (acc_n !== a0)         begin errors++; $display("FAIL bp_ignored: accepts %0d required %0d", acc_n, a0); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL bp_dbz: got %b required 0", div_by_zero); end
        out_ready = 1'b1;
        wait_idle();
    endtask

    task automatic test_reset_abort();
        int e;
        bit seen;
        out_ready = 1'b1;
        accept(4'd9, 4'd2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %b required 0", out_valid); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL abort_in_ready: got %b required 1", in_ready); end
        checks++; if (Q !== 4'd0)         begin errors++; $display("FAIL abort_q: got %0d required 0", Q); end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_resume: out_valid seen=%b required 0", seen); end
        accept(4'd9, 4'd2);
        wait_valid(e);
        checks++; if (e !== 5)    begin errors++; $display("FAIL abort_retry_latency: got %0d required 5", e); end
        checks++; if (Q !== 4'd4) begin errors++; $display("FAIL abort_retry_q: got %0d required 4", Q); end
        checks++; if (R !== 4'd1) begin errors++; $display("FAIL abort_retry_r: got %0d required 1", R); end
        wait_idle();
    endtask

    task automatic test_sweep();
        int e;
        logic [3:0] eq, er;
        logic       ed;
        out_ready = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) begin
                    eq = 4'hF; er = 4'(a); ed = 1'b1;
                end else begin
                    eq = 4'(a / b); er = 4'(a % b); ed = 1'b0;
                end
                accept(4'(a), 4'(b));
                wait_valid(e);
                checks++; if (out_valid !== 1'b1)  begin errors++; $display("FAIL sweep_valid: %0d/%0d got %b required 1", a, b, out_valid); end
                checks++; if (Q !== eq)            begin errors++; $display("FAIL sweep_q: %0d/%0d got %0d required %0d", a, b, Q, eq); end
                checks++; if (R !== er)            begin errors++; $display("FAIL sweep_r: %0d/%0d got %0d required %0d", a, b, R, er); end
                checks++; if (div_by_zero !== ed)  begin errors++; $display("FAIL sweep_dbz: %0d/%0d got %b required %b", a, b, div_by_zero, ed); end
                wait_idle();
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_back_to_back();
        test_backpressure();
        test_reset_abort();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_assertion_seq_divider
`default_nettype wire
